// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
// Round-robin arbiter and sequencer that time-shares one external combinational
// binary-to-BCD converter among N_REQ requesters. A winner's 12-bit value is
// registered onto conv_bin. The converter path then gets SETTLE+1 WAIT cycles.
// The digits are captured, with values above 999 saturating to 9/9/9 and
// setting ovf, and returned with a one-cycle one-hot ack.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req      [N_REQ]           level requests, bit i = requester i
//   bin_in   [N_REQ*12]        requester i value in [12i+11:12i]
//   ack      [N_REQ]           one-hot result-valid pulse
//   gnt_id   [ID_W]            requester being served
//   huns/tens/ones [4]         captured BCD digits
//   ovf                        captured value was > 999
//   busy                       high in WAIT and DONE
//   conv_bin [12]              registered drive to the shared converter
//   conv_huns/tens/ones [4]    shared converter outputs
module bcd_conv_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*12-1:0] bin_in,
  output logic [N_REQ-1:0]   ack,
  output logic [ID_W-1:0]    gnt_id,
  output logic [3:0]         huns,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic               ovf,
  output logic               busy,
  output logic [11:0]        conv_bin,
  input  logic [3:0]         conv_huns,
  input  logic [3:0]         conv_tens,
  input  logic [3:0]         conv_ones
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [11:0]       conv_bin_q, conv_bin_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [3:0]        huns_q, huns_d, tens_q, tens_d, ones_q, ones_d;
  logic              ovf_q, ovf_d;
  logic [N_REQ-1:0]  ack_q, ack_d;

  // Winner search: first set req bit at or above ptr, wrapping around.
  logic              found;
  logic [ID_W-1:0]   win;
  logic [11:0]       win_bin;
  int                idx;

  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_bin = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win     = ID_W'(idx);
        win_bin = bin_in[idx*12 +: 12];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    conv_bin_d = conv_bin_q;
    ovf_pend_d = ovf_pend_q;
    huns_d     = huns_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    ovf_d      = ovf_q;
    ack_d      = '0;
    case (state_q)
      IDLE: if (found) begin
        conv_bin_d = win_bin;
        gnt_d      = win;
        ovf_pend_d = (win_bin > 12'd999);
        cnt_d      = 4'(SETTLE);
        ptr_d      = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Out-of-range inputs never use the converter digits.
          huns_d  = ovf_pend_q ? 4'd9 : conv_huns;
          tens_d  = ovf_pend_q ? 4'd9 : conv_tens;
          ones_d  = ovf_pend_q ? 4'd9 : conv_ones;
          ovf_d   = ovf_pend_q;
          ack_d   = N_REQ'(1) << gnt_q;
          state_d = DONE;
        end
      end
      // req is ignored here so the served requester can drop it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      conv_bin_q <= '0;
      ovf_pend_q <= 1'b0;
      huns_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      conv_bin_q <= conv_bin_d;
      ovf_pend_q <= ovf_pend_d;
      huns_q     <= huns_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign gnt_id   = gnt_q;
  assign huns     = huns_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != IDLE);
  assign conv_bin = conv_bin_q;

endmodule
